bus_mux_arbiter: RTL and testbench



---
 rtl/bus_mux_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_mux_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_arbiter.sv
// ---------------------------------------------------------------------------
// bus_mux_arbiter
//   Round-robin arbiter/sequencer in front of the shared 4:1 tri-state bus
//   mux. Grants one requester at a time, drives the mux selects and the
//   final-stage buffer enable, and preempts an owner that has held the bus
//   for MAX_HOLD cycles while someone else is waiting.
//
//   Optional feature macro: BUS_ARB_TURNAROUND_EN
//     defined   -> one TURN cycle (all buffers off) between owners
//     undefined -> back-to-back handoff, no dead cycle
//
// Parameters
//   MAX_HOLD  max consecutive GRANT cycles while another req is pending (2..255)
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [3:0] request vector, level held while bus is wanted
//   gnt     out  [3:0] one-hot grant or zero (registered)
//   sel     out  [1:0] index of current/most recent owner (registered)
//   bus_en  out  tri-state stage enable, high only while granted (registered)
//   busy    out  high whenever the FSM is not IDLE (registered)
// ---------------------------------------------------------------------------
module bus_mux_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       bus_en,
   output logic       busy
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
`ifdef BUS_ARB_TURNAROUND_EN
      TURN  = 2'd2,
`endif
      GRANT = 2'd1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] sel_q, sel_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] gnt_q, gnt_d;
   logic       bus_en_q, bus_en_d;
   logic       busy_q, busy_d;

   // Round-robin search: scans p+1, p+2, p+3, p. Iterating from lowest to
   // highest priority lets the highest-priority hit overwrite the result.
   // Returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   logic [3:0] own_oh;
   logic       others;
   logic       release_own;
   logic [2:0] pick_all;
   logic [2:0] pick_oth;

   always_comb begin
      own_oh      = 4'b0001 << sel_q;
      others      = |(req & ~own_oh);
      // voluntary drop, or forced preemption once the hold limit is reached
      release_own = !req[sel_q] || ((hold_q == HOLD_LAST) && others);
      pick_all    = rr_pick(req, ptr_q);
      // ptr_q equals the owner while granted, so the owner would be last
      // anyway; masking removes it completely for direct handoff
      pick_oth    = rr_pick(req & ~own_oh, ptr_q);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      case (state_q)
         GRANT: begin
            if (release_own) begin
               hold_d = 8'd0;
`ifdef BUS_ARB_TURNAROUND_EN
               state_d = TURN;
`else
               if (pick_oth[2]) begin
                  state_d = GRANT;
                  ptr_d   = pick_oth[1:0];
                  sel_d   = pick_oth[1:0];
               end else begin
                  state_d = IDLE;
               end
`endif
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 8'd1;
            end
         end
`ifdef BUS_ARB_TURNAROUND_EN
         TURN: begin
            hold_d = 8'd0;
            if (pick_all[2]) begin
               state_d = GRANT;
               ptr_d   = pick_all[1:0];
               sel_d   = pick_all[1:0];
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            hold_d = 8'd0;
            if (pick_all[2]) begin
               state_d = GRANT;
               ptr_d   = pick_all[1:0];
               sel_d   = pick_all[1:0];
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Outputs are computed from the next state so they are registered
   // without adding a cycle of latency.
   always_comb begin
      bus_en_d = (state_d == GRANT);
      gnt_d    = bus_en_d ? (4'b0001 << sel_d) : 4'b0000;
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd3;
         sel_q    <= 2'd0;
         hold_q   <= 8'd0;
         gnt_q    <= 4'b0000;
         bus_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         hold_q   <= hold_d;
         gnt_q    <= gnt_d;
         bus_en_q <= bus_en_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign sel    = sel_q;
   assign bus_en = bus_en_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_mux_arbiter
//   Directed bench for bus_mux_arbiter. A behavioural owner/rotation model
//   is compared against the DUT on every falling edge; directed scenarios
//   add literal expectations for reset, single grants, rotation, preemption,
//   handoff and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_bus_mux_arbiter;

   localparam int MAX_HOLD = 8;
`ifdef BUS_ARB_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       bus_en;
   logic       busy;

   int  n_run  = 0;
   int  n_fail = 0;
   bit  chk_en = 1'b0;

   bus_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt), .sel(sel), .bus_en(bus_en), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner = -1 means nobody holds the bus; held counts granted cycles (1-based)
   int m_owner, m_last, m_held, m_sel;
   bit m_turn;

   function automatic int pick(input logic [3:0] r, input int after, input int excl);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (after + k) % 4;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int w;
      logic [3:0] oth;
      if (!rst_n) begin
         m_owner <= -1; m_last <= 3; m_held <= 0; m_sel <= 0; m_turn <= 1'b0;
      end else if (m_owner < 0) begin
         w = pick(req, m_last, -1);
         m_turn <= 1'b0;
         if (w >= 0) begin
            m_owner <= w; m_last <= w; m_sel <= w; m_held <= 1;
         end
      end else begin
         oth = req;
         oth[m_owner] = 1'b0;
         if (!req[m_owner] || (m_held >= MAX_HOLD && oth != 4'b0000)) begin
            if (TURN_EN) begin
               m_owner <= -1; m_turn <= 1'b1;
            end else begin
               w = pick(req, m_owner, m_owner);
               if (w >= 0) begin
                  m_owner <= w; m_last <= w; m_sel <= w; m_held <= 1;
               end else begin
                  m_owner <= -1;
               end
            end
         end else begin
            m_held <= m_held + 1;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] eg;
      if (chk_en && rst_n) begin
         eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         chk("model_gnt", gnt, eg);
         chk("model_sel", sel, m_sel);
         chk("model_bus_en", bus_en, m_owner >= 0);
         chk("model_busy", busy, (m_owner >= 0) || m_turn);
         chk("inv_onehot0", $onehot0(gnt), 1);
         chk("inv_bus_en", bus_en, |gnt);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return i;
      return -1;
   endfunction

   initial begin
      int n1;
      bit got3, got1;
      int run_own[$];
      int run_len[$];
      int dead;

      #2 rst_n = 1'b0;
      #20 rst_n = 1'b1;
      chk_en = 1'b1;

      // a: reset state held with no requests
      for (int c = 0; c < 10; c++) begin
         step();
         chk("a_idle_gnt", gnt, 4'b0000);
         chk("a_idle_sel", sel, 2'd0);
         chk("a_idle_bus_en", bus_en, 1'b0);
         chk("a_idle_busy", busy, 1'b0);
      end

      // b: single request from IDLE, then drop
      req = 4'b0100;
      step();
      chk("b_gnt", gnt, 4'b0100);
      chk("b_sel", sel, 2'd2);
      chk("b_bus_en", bus_en, 1'b1);
      req = 4'b0000;
      step();
      chk("b_drop_gnt", gnt, 4'b0000);
      chk("b_drop_bus_en", bus_en, 1'b0);
      chk("b_drop_busy", busy, TURN_EN);
      step();
      chk("b_idle_busy", busy, 1'b0);

      // c: lone requester is never preempted
      req = 4'b0001;
      step();
      for (int c = 0; c < 30; c++) begin
         chk("c_lone_gnt", gnt, 4'b0001);
         step();
      end
      req = 4'b0000;
      step(); step();

      // d: owner 1 preempted by req[3] after MAX_HOLD cycles
      req = 4'b0010;
      step();
      chk("d_grant1", gnt, 4'b0010);
      step();
      req = 4'b1010;
      n1 = 2; got3 = 1'b0;
      for (int c = 0; c < 20 && !got3; c++) begin
         step();
         if (gnt == 4'b0010) n1++;
         else if (gnt == 4'b1000) got3 = 1'b1;
      end
      chk("d_preempt_to3", got3, 1'b1);
      chk("d_hold_len", n1, MAX_HOLD);
      step(); chk("d_owner3_holds", gnt, 4'b1000);
      step(); chk("d_owner3_holds", gnt, 4'b1000);
      req = 4'b0010;
      got1 = 1'b0;
      for (int c = 0; c < 5 && !got1; c++) begin
         step();
         if (gnt == 4'b0010) got1 = 1'b1;
      end
      chk("d_regrant1", got1, 1'b1);
      req = 4'b0000;
      step(); step();

      // e: owner 2 drops as req[0] rises in the same cycle
      req = 4'b0100;
      step();
      chk("e_grant2", gnt, 4'b0100);
      req = 4'b0001;
      step();
`ifdef BUS_ARB_TURNAROUND_EN
      chk("e_turn_gnt", gnt, 4'b0000);
      chk("e_turn_bus_en", bus_en, 1'b0);
      chk("e_turn_sel", sel, 2'd2);
      step();
`endif
      chk("e_handoff_gnt", gnt, 4'b0001);
      chk("e_handoff_sel", sel, 2'd0);
      chk("e_handoff_bus_en", bus_en, 1'b1);

      // asynchronous reset mid-grant: outputs clear between clock edges
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("r_async_gnt", gnt, 4'b0000);
      chk("r_async_bus_en", bus_en, 1'b0);
      chk("r_async_sel", sel, 2'd0);
      chk("r_async_busy", busy, 1'b0);
      req = 4'b0000;
      #1 rst_n = 1'b1;
      step(); step();

      // f: all four requesting, rotation 0,1,2,3,0 with MAX_HOLD each
      req = 4'b1111;
      dead = 0;
      for (int c = 0; c < 44; c++) begin
         step();
         if (gnt == 4'b0000) dead++;
         else if (run_own.size() == 0 || run_own[$] != idx_of(gnt)) begin
            run_own.push_back(idx_of(gnt));
            run_len.push_back(1);
         end else begin
            run_len[$] = run_len[$] + 1;
         end
      end
      chk("f_run_count_ge5", run_own.size() >= 5, 1'b1);
      if (run_own.size() >= 5) begin
         chk("f_own0", run_own[0], 0);
         chk("f_own1", run_own[1], 1);
         chk("f_own2", run_own[2], 2);
         chk("f_own3", run_own[3], 3);
         chk("f_own4", run_own[4], 0);
         for (int i = 0; i < 4; i++) chk("f_len", run_len[i], MAX_HOLD);
      end
      chk("f_dead_cycles", dead, TURN_EN ? 4 : 0);
      req = 4'b0000;
      step(); step(); step();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
